// File: rtl/pe_comp_sched.sv
// pe_comp_sched: per-PE computation scheduler for the address-computation stage.
// Each accepted input activation is expanded into a train of one-per-cycle
// compute ops: W ops (full-rank) or V ops (low-rank). In low-rank layers the
// V phase for the last activation is followed by a U sweep over all
// (output, rank) pairs. A start pulse begins a layer; done pulses once at the end.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, lr_mode, layer_idx_in, out_act_no, rank_no_in   layer config (sampled on start)
//   in_valid/in_ready, in_idx, in_value, in_last           activation input handshake
//   stall                    downstream back-pressure
//   comp_en, layer_idx, in_act_idx, in_act_value, out_act_addr, rank_no   issued op (registered)
//   busy, done               layer status
module pe_comp_sched #(
  parameter int ADDR_W   = 16,
  parameter int ACT_NO_W = 6,
  parameter int RANK_W   = 6,
  parameter int DATA_W   = 16,
  parameter int LAYER_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                lr_mode,
  input  logic [LAYER_W-1:0]  layer_idx_in,
  input  logic [ACT_NO_W-1:0] out_act_no,
  input  logic [RANK_W-1:0]   rank_no_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_idx,
  input  logic [DATA_W-1:0]   in_value,
  input  logic                in_last,
  input  logic                stall,
  output logic [1:0]          comp_en,
  output logic [LAYER_W-1:0]  layer_idx,
  output logic [ADDR_W-1:0]   in_act_idx,
  output logic [DATA_W-1:0]   in_act_value,
  output logic [ACT_NO_W-1:0] out_act_addr,
  output logic [RANK_W-1:0]   rank_no,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] COMP_EN_IDLE = 2'd0;
  localparam logic [1:0] COMP_EN_W    = 2'd1;
  localparam logic [1:0] COMP_EN_U    = 2'd2;
  localparam logic [1:0] COMP_EN_V    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_ACT, S_ISSUE_W, S_ISSUE_V, S_ISSUE_U, S_FINISH
  } state_t;

  state_t              state, state_n;
  logic [ACT_NO_W-1:0] o_cnt, o_n;     // output-row counter (W rows, U outer loop)
  logic [RANK_W-1:0]   r_cnt, r_n;     // rank counter (V rows, U inner loop)
  logic                lr_q, lr_n;
  logic [ACT_NO_W-1:0] ono_q, ono_n;
  logic [ADDR_W-1:0]   idx_q, idx_n;
  logic [DATA_W-1:0]   val_q, val_n;
  logic                last_q, last_n;

  logic [1:0]          comp_en_n;
  logic [LAYER_W-1:0]  layer_idx_n;
  logic [ADDR_W-1:0]   in_act_idx_n;
  logic [DATA_W-1:0]   in_act_value_n;
  logic [ACT_NO_W-1:0] out_act_addr_n;
  logic [RANK_W-1:0]   rank_no_n;
  logic                busy_n;

  // State that follows the end of a V/W loop (or an empty loop).
  function automatic state_t post_loop(input logic last, input logic lr,
                                       input logic [ACT_NO_W-1:0] ono,
                                       input logic [RANK_W-1:0] rank);
    if (!last)                        return S_WAIT_ACT;
    else if (!lr)                     return S_FINISH;
    else if (ono == '0 || rank == '0) return S_FINISH;
    else                              return S_ISSUE_U;
  endfunction

  // Only the state register drives in_ready; stall gates it combinationally so
  // an activation is never accepted in a frozen cycle.
  assign in_ready = (state == S_WAIT_ACT) && !stall;

  always_comb begin
    state_n        = state;
    o_n            = o_cnt;
    r_n            = r_cnt;
    lr_n           = lr_q;
    ono_n          = ono_q;
    idx_n          = idx_q;
    val_n          = val_q;
    last_n         = last_q;
    comp_en_n      = COMP_EN_IDLE;
    layer_idx_n    = layer_idx;
    in_act_idx_n   = in_act_idx;
    in_act_value_n = in_act_value;
    out_act_addr_n = out_act_addr;
    rank_no_n      = rank_no;
    busy_n         = busy;
    case (state)
      S_IDLE: begin
        if (start) begin
          lr_n        = lr_mode;
          layer_idx_n = layer_idx_in;
          ono_n       = out_act_no;
          rank_no_n   = rank_no_in;
          busy_n      = 1'b1;
          state_n     = S_WAIT_ACT;
        end
      end
      S_WAIT_ACT: begin
        if (in_valid && in_ready) begin
          idx_n  = in_idx;
          val_n  = in_value;
          last_n = in_last;
          o_n    = '0;
          r_n    = '0;
          if (lr_q) state_n = (rank_no == '0) ? post_loop(in_last, lr_q, ono_q, rank_no) : S_ISSUE_V;
          else      state_n = (ono_q == '0)   ? post_loop(in_last, lr_q, ono_q, rank_no) : S_ISSUE_W;
        end
      end
      S_ISSUE_W: begin
        if (!stall) begin
          comp_en_n      = COMP_EN_W;
          out_act_addr_n = o_cnt;
          in_act_idx_n   = idx_q;
          in_act_value_n = val_q;
          if (o_cnt == ono_q - ACT_NO_W'(1)) begin
            o_n     = '0;
            r_n     = '0;
            state_n = post_loop(last_q, lr_q, ono_q, rank_no);
          end else begin
            o_n = o_cnt + ACT_NO_W'(1);
          end
        end
      end
      S_ISSUE_V: begin
        if (!stall) begin
          comp_en_n      = COMP_EN_V;
          out_act_addr_n = ACT_NO_W'(r_cnt);
          in_act_idx_n   = idx_q;
          in_act_value_n = val_q;
          if (r_cnt == rank_no - RANK_W'(1)) begin
            o_n     = '0;
            r_n     = '0;
            state_n = post_loop(last_q, lr_q, ono_q, rank_no);
          end else begin
            r_n = r_cnt + RANK_W'(1);
          end
        end
      end
      S_ISSUE_U: begin
        if (!stall) begin
          comp_en_n      = COMP_EN_U;
          out_act_addr_n = o_cnt;
          in_act_idx_n   = ADDR_W'(r_cnt);
          in_act_value_n = '0;
          if (r_cnt == rank_no - RANK_W'(1)) begin
            r_n = '0;
            if (o_cnt == ono_q - ACT_NO_W'(1)) begin
              o_n     = '0;
              state_n = S_FINISH;
            end else begin
              o_n = o_cnt + ACT_NO_W'(1);
            end
          end else begin
            r_n = r_cnt + RANK_W'(1);
          end
        end
      end
      S_FINISH: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      o_cnt        <= '0;
      r_cnt        <= '0;
      lr_q         <= 1'b0;
      ono_q        <= '0;
      idx_q        <= '0;
      val_q        <= '0;
      last_q       <= 1'b0;
      comp_en      <= COMP_EN_IDLE;
      layer_idx    <= '0;
      in_act_idx   <= '0;
      in_act_value <= '0;
      out_act_addr <= '0;
      rank_no      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      o_cnt        <= o_n;
      r_cnt        <= r_n;
      lr_q         <= lr_n;
      ono_q        <= ono_n;
      idx_q        <= idx_n;
      val_q        <= val_n;
      last_q       <= last_n;
      comp_en      <= comp_en_n;
      layer_idx    <= layer_idx_n;
      in_act_idx   <= in_act_idx_n;
      in_act_value <= in_act_value_n;
      out_act_addr <= out_act_addr_n;
      rank_no      <= rank_no_n;
      busy         <= busy_n;
      done         <= (state == S_FINISH);
    end
  end

endmodule

// File: tb/tb_pe_comp_sched.sv
// Directed bench for pe_comp_sched: linear step sequence, hand-computed expectations.
module tb_pe_comp_sched;
  localparam int ADDR_W = 16, ACT_NO_W = 6, RANK_W = 6, DATA_W = 16, LAYER_W = 3;
  localparam int CE_IDLE = 0, CE_W = 1, CE_U = 2, CE_V = 3;

  logic                clk = 1'b0;
  logic                rst, start, lr_mode, in_valid, in_ready, in_last, stall, busy, done;
  logic [LAYER_W-1:0]  layer_idx_in, layer_idx;
  logic [ACT_NO_W-1:0] out_act_no, out_act_addr;
  logic [RANK_W-1:0]   rank_no_in, rank_no;
  logic [ADDR_W-1:0]   in_idx, in_act_idx;
  logic [DATA_W-1:0]   in_value, in_act_value;
  logic [1:0]          comp_en;

  int n_cmp = 0;
  int n_err = 0;

  pe_comp_sched #(.ADDR_W(ADDR_W), .ACT_NO_W(ACT_NO_W), .RANK_W(RANK_W),
                  .DATA_W(DATA_W), .LAYER_W(LAYER_W)) dut (
    .clk(clk), .rst(rst), .start(start), .lr_mode(lr_mode),
    .layer_idx_in(layer_idx_in), .out_act_no(out_act_no), .rank_no_in(rank_no_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx), .in_value(in_value),
    .in_last(in_last), .stall(stall), .comp_en(comp_en), .layer_idx(layer_idx),
    .in_act_idx(in_act_idx), .in_act_value(in_act_value), .out_act_addr(out_act_addr),
    .rank_no(rank_no), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_op(input string tag, input int ce, input int addr, input int idx, input int val);
    chk({tag, ".ce"},   32'(comp_en), 32'(ce));
    chk({tag, ".addr"}, 32'(out_act_addr), 32'(addr));
    chk({tag, ".idx"},  32'(in_act_idx), 32'(idx));
    chk({tag, ".val"},  32'(in_act_value), 32'(val));
  endtask

  task automatic cfg(input logic lr, input int layer, input int ono, input int rank);
    start = 1'b1; lr_mode = lr;
    layer_idx_in = LAYER_W'(layer); out_act_no = ACT_NO_W'(ono); rank_no_in = RANK_W'(rank);
    tick();
    start = 1'b0;
  endtask

  task automatic act(input int idx, input int val, input logic last);
    in_valid = 1'b1; in_idx = ADDR_W'(idx); in_value = DATA_W'(val); in_last = last;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; lr_mode = 1'b0; layer_idx_in = '0; out_act_no = '0;
    rank_no_in = '0; in_valid = 1'b0; in_idx = '0; in_value = '0; in_last = 1'b0; stall = 1'b0;
    tick(); tick();
    chk_op("rst", CE_IDLE, 0, 0, 0);
    chk("rst.ready", 32'(in_ready), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.layer", 32'(layer_idx), 0);
    chk("rst.rank", 32'(rank_no), 0);
    rst = 1'b0;
    tick();

    // W mode, 3 rows, single last activation
    cfg(1'b0, 2, 3, 0);
    chk("w.busy", 32'(busy), 1);
    chk("w.layer", 32'(layer_idx), 2);
    chk("w.ready", 32'(in_ready), 1);
    stall = 1'b1; #1;
    chk("w.ready_stall", 32'(in_ready), 0);
    stall = 1'b0; #1;
    act(5, 16'h0010, 1'b1);
    chk("w.acc_ce", 32'(comp_en), CE_IDLE);
    chk("w.acc_ready", 32'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_op($sformatf("w.op%0d", i), CE_W, i, 5, 16'h0010);
      chk($sformatf("w.done%0d", i), 32'(done), 0);
    end
    tick();
    chk("w.done", 32'(done), 1);
    chk("w.fin_ce", 32'(comp_en), CE_IDLE);
    chk("w.busy_fall", 32'(busy), 0);
    tick();
    chk("w.done_pulse", 32'(done), 0);

    // LR mode: rank 2, 2 outputs, two activations, then U sweep
    cfg(1'b1, 5, 2, 2);
    chk("lr.rank", 32'(rank_no), 2);
    act(1, 7, 1'b0);
    tick(); chk_op("lr.v0", CE_V, 0, 1, 7);
    tick(); chk_op("lr.v1", CE_V, 1, 1, 7);
    chk("lr.ready_again", 32'(in_ready), 1);
    act(4, 9, 1'b1);
    chk("lr.gap_ce", 32'(comp_en), CE_IDLE);
    tick(); chk_op("lr.v2", CE_V, 0, 4, 9);
    tick(); chk_op("lr.v3", CE_V, 1, 4, 9);
    tick(); chk_op("lr.u00", CE_U, 0, 0, 0);
    tick(); chk_op("lr.u01", CE_U, 0, 1, 0);
    tick(); chk_op("lr.u10", CE_U, 1, 0, 0);
    tick(); chk_op("lr.u11", CE_U, 1, 1, 0);
    chk("lr.done_early", 32'(done), 0);
    tick();
    chk("lr.done", 32'(done), 1);
    chk("lr.busy", 32'(busy), 0);

    // Stall 3 cycles mid ISSUE_W with row 1 pending
    tick();
    cfg(1'b0, 0, 4, 0);
    act(7, 16'h0022, 1'b1);
    tick(); chk_op("st.op0", CE_W, 0, 7, 16'h0022);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_op($sformatf("st.hold%0d", i), CE_IDLE, 0, 7, 16'h0022);
      chk($sformatf("st.ready%0d", i), 32'(in_ready), 0);
    end
    stall = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_op($sformatf("st.op%0d", i), CE_W, i, 7, 16'h0022);
    end
    tick();
    chk("st.done", 32'(done), 1);

    // Zero output count: activation consumed, no ops, done within 2 cycles
    tick();
    cfg(1'b0, 4, 0, 0);
    act(3, 1, 1'b1);
    chk("z.ce0", 32'(comp_en), CE_IDLE);
    tick();
    chk("z.ce1", 32'(comp_en), CE_IDLE);
    chk("z.done", 32'(done), 1);
    chk("z.busy", 32'(busy), 0);

    // start and in_valid held during ISSUE_W are ignored
    tick();
    cfg(1'b0, 1, 2, 0);
    in_valid = 1'b1; in_idx = 16'd8; in_value = 16'h0033; in_last = 1'b1;
    tick();
    in_idx = 16'd9; start = 1'b1; layer_idx_in = 3'd6; out_act_no = 6'd5;
    chk("ig.ready", 32'(in_ready), 0);
    tick(); chk_op("ig.op0", CE_W, 0, 8, 16'h0033);
    chk("ig.layer", 32'(layer_idx), 1);
    chk("ig.ready1", 32'(in_ready), 0);
    tick(); chk_op("ig.op1", CE_W, 1, 8, 16'h0033);
    start = 1'b0; in_valid = 1'b0;
    tick();
    chk("ig.done", 32'(done), 1);
    chk("ig.layer_fin", 32'(layer_idx), 1);

    // Reset during ISSUE_U, then a clean layer
    tick();
    cfg(1'b1, 3, 2, 2);
    act(2, 5, 1'b1);
    tick(); tick(); tick();
    chk_op("ru.u00", CE_U, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_op("ru.rst", CE_IDLE, 0, 0, 0);
    chk("ru.busy", 32'(busy), 0);
    chk("ru.done", 32'(done), 0);
    chk("ru.layer", 32'(layer_idx), 0);
    chk("ru.rank", 32'(rank_no), 0);
    chk("ru.ready", 32'(in_ready), 0);
    tick();
    chk("ru.no_done", 32'(done), 0);
    cfg(1'b0, 7, 1, 0);
    act(11, 16'h0044, 1'b1);
    tick(); chk_op("ru.op", CE_W, 0, 11, 16'h0044);
    tick();
    chk("ru.done2", 32'(done), 1);
    chk("ru.layer2", 32'(layer_idx), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
